wb_ram_arbiter: RTL and testbench
=================================

Name: wb_ram_arbiter

Overview:
- Wishbone B3 arbiter that shares the tile's single ram_wb_b3 slave port between NR_MASTERS bus masters. Typical masters are the network adapter DMA master and a debug/CPU master.
- Arbitration is round-robin, and a grant is held for a full cyc tenure.
- A per-access watchdog terminates hung accesses with err.
- The block sits between the masters and the RAM slave in compute tiles.

Parameters:
NR_MASTERS  2  number of requesting Wishbone masters, 2..8
TIMEOUT  255  cycles a strobed access may wait for ack/err before a forced err; 0 disables the watchdog
CNT_WIDTH  8  watchdog counter width; must satisfy TIMEOUT < 2**CNT_WIDTH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
m_adr_i_flat  in  32*NR_MASTERS  master addresses; master k uses bits [32k+31:32k]
m_dat_i_flat  in  32*NR_MASTERS  master write data
m_sel_i_flat  in  4*NR_MASTERS  master byte selects
m_cyc_i  in  NR_MASTERS  master cycle request
m_stb_i  in  NR_MASTERS  master strobe
m_we_i  in  NR_MASTERS  master write enable
m_ack_o  out  NR_MASTERS  ack routed to master
m_err_o  out  NR_MASTERS  err routed to master
m_dat_o  out  32  read data broadcast to all masters; valid only with own ack
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_sel_o  out  4  slave byte selects
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err
s_dat_i  in  32  slave read data
grant_o  out  NR_MASTERS  one-hot current grant, registered
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
Reset:
- Reset is asynchronous and active-low: rst_n=0 immediately clears all state.
- State is IDLE, grant_o=0, timeout_o=0 and the watchdog counter is 0.
- rr_ptr=0, so master 0 has the highest priority first.
- With no grant, s_cyc_o, s_stb_o, s_we_o, m_ack_o and m_err_o are 0. s_adr_o, s_dat_o and s_sel_o are 0 when no master is granted.

State machine (IDLE, BUSY):
- IDLE: if any m_cyc_i is high, select the first requester scanning from rr_ptr upward, modulo NR_MASTERS.
- The selection is registered into grant_o, with a transition to BUSY at the next edge. Arbitration latency is one cycle: the slave first sees the granted master's signals in the cycle after the request is sampled.
- BUSY: s_* outputs are combinationally muxed from the granted master. s_cyc_o and s_stb_o are additionally gated by the grant.
- BUSY response routing: m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i, combinationally, where g is the granted master. All non-granted masters see ack=err=0.
- BUSY release: when m_cyc_i[g]=0, the next edge returns to IDLE, clears grant_o and sets rr_ptr=(g+1) mod NR_MASTERS.
- There is one mandatory IDLE cycle between tenures, and no re-grant occurs in the release cycle.

Tenure rules:
- The grant is never preempted while m_cyc_i[g] stays high. Multiple strobed accesses (blocks or RMW) are allowed within one tenure.
- Non-granted masters simply stall; there is no retry or error for them.
- ack and cyc falling in the same cycle: the ack is still delivered to g, then release follows.
- A master that drops cyc while its stb is still pending abandons the access. The slave sees cyc=0 in that cycle.

Watchdog:
- The counter increments each BUSY cycle with s_stb_o=1, s_ack_i=0 and s_err_i=0.
- It clears on ack, on err, when stb=0, and in IDLE.
- When count==TIMEOUT-1 with no response:
  - m_err_o[g] and timeout_o pulse high for one cycle;
  - s_stb_o is forced to 0 in that cycle;
  - the counter clears.
- If s_ack_i or s_err_i arrives in the same cycle the watchdog would fire, the slave response wins and no timeout is generated.
- TIMEOUT=0 disables the watchdog: the counter stays 0 and timeout_o stays 0.

Widths and data:
- The counter saturates, never wraps.
- m_dat_o = s_dat_i unconditionally.

Test Plan:
- Single master: after reset, m_cyc_i=01 with a write of 0xDEADBEEF to 0x100 and sel=F.
  -> grant_o=01 after one cycle; s_adr_o=0x100; s_dat_o=0xDEADBEEF; m_ack_o=01 when the slave acks; readback of 0x100 returns 0xDEADBEEF.
- Simultaneous request after reset with m_cyc_i=11.
  -> Master 0 is granted first.
  -> After master 0 drops cyc, one IDLE cycle follows, then grant_o=10.
  -> After the next simultaneous request, master 0 wins again (alternation).
- Hold: master 0 performs 4 back-to-back strobed reads while master 1 requests.
  -> grant_o stays 01 for all 4 acks.
  -> m_ack_o[1] stays 0 throughout.
  -> Master 1 is granted only after master 0 releases.
- Watchdog with TIMEOUT=4: the slave never acks.
  -> m_err_o[g] and timeout_o are high in the 4th strobed cycle.
  -> s_stb_o=0 in that cycle.
  -> The counter restarts from 0.
- Reset mid-tenure: assert rst_n=0 during BUSY with stb high.
  -> grant_o, s_cyc_o and s_stb_o go to 0 immediately (asynchronously).
  -> After release, m_cyc_i=10 is granted to master 1 with rr_ptr=0.
- Same-cycle events:
  -> ack coincident with cyc deassertion: the ack is delivered and the block releases.
  -> ack coincident with watchdog expiry: no timeout_o pulse.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// rtl/wb_ram_arbiter.sv - round-robin Wishbone B3 arbiter for the shared tile RAM port
// A grant is held for a whole cyc tenure; a per-access watchdog turns hung strobes into err.
module wb_ram_arbiter #(
    parameter int NR_MASTERS = 2,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [32*NR_MASTERS-1:0]   m_adr_i_flat,
    input  logic [32*NR_MASTERS-1:0]   m_dat_i_flat,
    input  logic [4*NR_MASTERS-1:0]    m_sel_i_flat,
    input  logic [NR_MASTERS-1:0]      m_cyc_i,
    input  logic [NR_MASTERS-1:0]      m_stb_i,
    input  logic [NR_MASTERS-1:0]      m_we_i,
    output logic [NR_MASTERS-1:0]      m_ack_o,
    output logic [NR_MASTERS-1:0]      m_err_o,
    output logic [31:0]                m_dat_o,
    output logic [31:0]                s_adr_o,
    output logic [31:0]                s_dat_o,
    output logic [3:0]                 s_sel_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,
    input  logic [31:0]                s_dat_i,
    output logic [NR_MASTERS-1:0]      grant_o,
    output logic                       timeout_o
);

    localparam int IDX_W = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam bit WD_EN = (TIMEOUT > 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NR_MASTERS-1:0]   r_grant;
    logic [NR_MASTERS-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]        r_gidx;
    logic [IDX_W-1:0]        w_gidx_nxt;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        w_rr_ptr_nxt;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;

    logic                    w_busy;
    logic                    w_req_found;
    logic [IDX_W-1:0]        w_req_idx;
    logic [IDX_W:0]          w_scan;
    logic                    w_g_cyc;
    logic                    w_g_stb;
    logic                    w_g_we;
    logic [31:0]             w_g_adr;
    logic [31:0]             w_g_dat;
    logic [3:0]              w_g_sel;
    logic                    w_pending;
    logic                    w_fire;

    // First requester at or above rr_ptr, wrapping modulo NR_MASTERS.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = '0;
        w_scan      = '0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_scan >= (IDX_W+1)'(NR_MASTERS)) begin
                w_scan = w_scan - (IDX_W+1)'(NR_MASTERS);
            end
            if (!w_req_found && m_cyc_i[w_scan[IDX_W-1:0]]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        w_g_we  = 1'b0;
        w_g_adr = '0;
        w_g_dat = '0;
        w_g_sel = '0;
        for (int k = 0; k < NR_MASTERS; k++) begin
            if (r_gidx == IDX_W'(k)) begin
                w_g_cyc = m_cyc_i[k];
                w_g_stb = m_stb_i[k];
                w_g_we  = m_we_i[k];
                w_g_adr = m_adr_i_flat[32*k +: 32];
                w_g_dat = m_dat_i_flat[32*k +: 32];
                w_g_sel = m_sel_i_flat[4*k +: 4];
            end
        end
    end

    assign w_busy    = (r_state == ST_BUSY);
    assign w_pending = w_busy && w_g_cyc && w_g_stb && !s_ack_i && !s_err_i;
    // A slave response in the expiry cycle wins over the watchdog.
    assign w_fire    = WD_EN && w_pending && (r_cnt == CNT_LAST);

    assign s_cyc_o   = w_busy & w_g_cyc;
    assign s_stb_o   = w_busy & w_g_cyc & w_g_stb & ~w_fire;
    assign s_we_o    = w_busy & w_g_we;
    assign s_adr_o   = w_busy ? w_g_adr : 32'h0;
    assign s_dat_o   = w_busy ? w_g_dat : 32'h0;
    assign s_sel_o   = w_busy ? w_g_sel : 4'h0;
    assign m_ack_o   = (w_busy && s_ack_i) ? r_grant : '0;
    assign m_err_o   = (w_busy && (s_err_i || w_fire)) ? r_grant : '0;
    assign m_dat_o   = s_dat_i;
    assign grant_o   = r_grant;
    assign timeout_o = w_fire;

    always_comb begin
        w_cnt_nxt = '0;
        if (WD_EN && w_pending && !w_fire) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_req_found) begin
                    w_state_nxt = ST_BUSY;
                    w_gidx_nxt  = w_req_idx;
                    w_grant_nxt = NR_MASTERS'(1) << w_req_idx;
                end
            end
            ST_BUSY: begin
                // Release always passes through IDLE, so no re-grant in this cycle.
                if (!w_g_cyc) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = (r_gidx == IDX_W'(NR_MASTERS-1)) ? '0 : r_gidx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb/tb_wb_ram_arbiter.sv - directed vector bench for wb_ram_arbiter
// Two masters, TIMEOUT=4, small word RAM acting as the slave.
module tb_wb_ram_arbiter;

    localparam logic [31:0] A  = 32'h0000_0100;
    localparam logic [31:0] D  = 32'hDEAD_BEEF;
    localparam logic [31:0] B0 = 32'h0000_0200;
    localparam logic [31:0] P  = 32'h1111_1111;
    localparam logic [31:0] B1 = 32'h0000_0300;
    localparam logic [31:0] Q  = 32'h2222_2222;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] m_adr_i_flat;
    logic [63:0] m_dat_i_flat;
    logic [7:0]  m_sel_i_flat;
    logic [1:0]  m_cyc_i;
    logic [1:0]  m_stb_i;
    logic [1:0]  m_we_i;
    logic [1:0]  m_ack_o;
    logic [1:0]  m_err_o;
    logic [31:0] m_dat_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic        s_ack_i;
    logic        s_err_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter #(.NR_MASTERS(2), .TIMEOUT(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_adr_i_flat(m_adr_i_flat), .m_dat_i_flat(m_dat_i_flat), .m_sel_i_flat(m_sel_i_flat),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    logic [31:0] mem [0:255] = '{default: 32'h0};
    assign s_dat_i = mem[s_adr_o[9:2]];
    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) mem[s_adr_o[9:2]] <= s_dat_o;
    end

    typedef struct {
        logic        rst;
        logic [1:0]  cyc, stb, we;
        logic [31:0] adr0, dat0;
        logic        ack, err;
        logic [1:0]  e_grant;
        logic        e_scyc, e_sstb, e_swe;
        logic [31:0] e_sadr, e_sdat;
        logic [1:0]  e_mack, e_merr;
        logic        e_to;
        logic [31:0] e_mdat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                                input logic [1:0] we, input logic [31:0] adr0, input logic [31:0] dat0,
                                input logic ack, input logic err, input logic [1:0] g, input logic sc,
                                input logic ss, input logic sw, input logic [31:0] sa, input logic [31:0] sd,
                                input logic [1:0] ma, input logic [1:0] me, input logic to, input logic [31:0] md);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.adr0 = adr0; v.dat0 = dat0;
        v.ack = ack; v.err = err; v.e_grant = g; v.e_scyc = sc; v.e_sstb = ss; v.e_swe = sw;
        v.e_sadr = sa; v.e_sdat = sd; v.e_mack = ma; v.e_merr = me; v.e_to = to; v.e_mdat = md;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        logic [3:0] e_sel;
        e_sel = (v.e_grant == 2'b01) ? 4'hF : ((v.e_grant == 2'b10) ? 4'h3 : 4'h0);
        check({tag, " grant"},   32'(grant_o),   32'(v.e_grant));
        check({tag, " s_cyc"},   32'(s_cyc_o),   32'(v.e_scyc));
        check({tag, " s_stb"},   32'(s_stb_o),   32'(v.e_sstb));
        check({tag, " s_we"},    32'(s_we_o),    32'(v.e_swe));
        check({tag, " s_adr"},   s_adr_o,        v.e_sadr);
        check({tag, " s_dat"},   s_dat_o,        v.e_sdat);
        check({tag, " s_sel"},   32'(s_sel_o),   32'(e_sel));
        check({tag, " m_ack"},   32'(m_ack_o),   32'(v.e_mack));
        check({tag, " m_err"},   32'(m_err_o),   32'(v.e_merr));
        check({tag, " timeout"}, 32'(timeout_o), 32'(v.e_to));
        check({tag, " m_dat"},   m_dat_o,        v.e_mdat);
    endtask

    initial begin
        rst_n = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i_flat = {B1, A}; m_dat_i_flat = {Q, D}; m_sel_i_flat = {4'h3, 4'hF};
        s_ack_i = 1'b0; s_err_i = 1'b0;

        // single-master write, readback, ack with cyc falling
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b01, A, D, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b01, A, D, 1, 0, 2'b01, 1, 1, 1, A, D, 2'b01, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, A, D, 1, 0, 2'b01, 1, 1, 0, A, D, 2'b01, 2'b00, 0, D));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, A, D, 1, 0, 2'b01, 0, 0, 0, A, D, 2'b01, 2'b00, 0, D));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, A, D, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        // reset, then simultaneous requests alternate
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, B0, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, B0, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, B0, P, 0, 0, 2'b01, 1, 0, 0, B0, P, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, B0, P, 0, 0, 2'b01, 0, 0, 0, B0, P, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, B0, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, B0, P, 0, 0, 2'b10, 1, 0, 0, B1, Q, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, B0, P, 0, 0, 2'b10, 0, 0, 0, B1, Q, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, A, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        // master 0 holds for 4 reads while master 1 strobes
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, A, P, 1, 0, 2'b01, 1, 1, 0, A, P, 2'b01, 2'b00, 0, D));
        vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, A, P, 0, 0, 2'b01, 0, 0, 0, A, P, 2'b00, 2'b00, 0, D));
        vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, A, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        // watchdog fires on the 4th unanswered strobe, then ack wins at expiry
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, A, P, 0, 0, 2'b10, 1, 1, 0, B1, Q, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, A, P, 0, 0, 2'b10, 1, 0, 0, B1, Q, 2'b00, 2'b10, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, A, P, 0, 0, 2'b10, 1, 1, 0, B1, Q, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, A, P, 1, 0, 2'b10, 1, 1, 0, B1, Q, 2'b10, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, A, P, 0, 0, 2'b10, 0, 0, 0, B1, Q, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, A, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        // asynchronous reset mid-tenure, then master 1 alone, then abandoned strobe
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, A, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, A, P, 0, 0, 2'b01, 1, 1, 0, A, P, 2'b00, 2'b00, 0, D));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, A, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, A, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, A, P, 0, 0, 2'b10, 1, 0, 0, B1, Q, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, A, P, 0, 0, 2'b10, 0, 0, 0, B1, Q, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, A, P, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

        @(negedge clk);
        check("reset grant",   32'(grant_o),   32'h0);
        check("reset s_cyc",   32'(s_cyc_o),   32'h0);
        check("reset s_stb",   32'(s_stb_o),   32'h0);
        check("reset timeout", 32'(timeout_o), 32'h0);
        check("reset s_adr",   s_adr_o,        32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst_n = ~vecs[i].rst;
            m_cyc_i = vecs[i].cyc; m_stb_i = vecs[i].stb; m_we_i = vecs[i].we;
            m_adr_i_flat = {B1, vecs[i].adr0}; m_dat_i_flat = {Q, vecs[i].dat0};
            s_ack_i = vecs[i].ack; s_err_i = vecs[i].err;
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // slave err is routed to the granted master without a timeout pulse
        @(posedge clk); #1;
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00; m_adr_i_flat = {B1, A};
        s_ack_i = 1'b0; s_err_i = 1'b0;
        @(posedge clk); #1;
        s_err_i = 1'b1;
        @(negedge clk);
        check("err grant",   32'(grant_o),   32'h1);
        check("err m_err",   32'(m_err_o),   32'h1);
        check("err m_ack",   32'(m_ack_o),   32'h0);
        check("err timeout", 32'(timeout_o), 32'h0);
        @(posedge clk); #1;
        s_err_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
        @(negedge clk);
        check("err release m_err", 32'(m_err_o), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err idle grant", 32'(grant_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
